// File: rtl/mux_arbiter4.sv
// mux_arbiter4: rotating-priority 4-way arbiter with hold limit, registered one-hot grant and mux select
module mux_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);
   typedef enum logic {IDLE, OWNED} state_t;
   state_t state_q, state_d;
   logic [3:0] gnt_q, gnt_d, hold_q, hold_d, others;
   logic [1:0] sel_q, sel_d, ptr_q, ptr_d, k;
   logic [2:0] pick_all, pick_oth;
   logic busy_q, busy_d, new_g;
   // {found, index} of the first set bit of m searching p, p+1, p+2, p+3 (mod 4)
   function automatic logic [2:0] first_in(input logic [3:0] m, input logic [1:0] p);
      logic [7:0] d;
      first_in = 3'b000;
      d = {m, m} >> p;
      for (int i = 3; i >= 0; i--)
         if (d[i]) first_in = {1'b1, p + 2'(i)};
   endfunction
   always_comb begin
      others   = req & ~(4'b0001 << sel_q);
      pick_all = first_in(req, ptr_q);
      pick_oth = first_in(others, ptr_q);
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      busy_d   = busy_q;
      new_g    = 1'b0;
      k        = 2'd0;
      if (state_q == IDLE) begin
         new_g = pick_all[2];
         k     = pick_all[1:0];
      end else if (req[sel_q] && hold_q != 4'(MAX_HOLD - 1)) begin
         hold_d = hold_q + 4'd1;
      end else begin
         new_g = pick_oth[2];
         k     = pick_oth[1:0];
         hold_d = 4'd0;
         if (!req[sel_q] && !pick_oth[2]) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      end
      if (new_g) begin
         state_d = OWNED;
         gnt_d   = 4'b0001 << k;
         sel_d   = k;
         ptr_d   = k + 2'd1;
         hold_d  = 4'd0;
         busy_d  = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         hold_q  <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end
   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_mux_arbiter4.sv
// tb_mux_arbiter4: directed and randomized checks of mux_arbiter4 against a behavioural model
module tb_mux_arbiter4;
   localparam int MAX_HOLD = 8;
   logic clk = 1'b0, reset = 1'b1;
   logic [3:0] req = 4'b0000, gnt;
   logic [1:0] sel;
   logic busy;
   int vectors = 0, errors = 0;
   int owner = -1, ptr_m = 0, hold_m = 0, sel_m = 0;
   int wait_c [4] = '{0, 0, 0, 0};
   logic [3:0] r;
   mux_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel), .busy(busy)
   );
   always #5 clk = ~clk;
   function automatic int first(input logic [3:0] m, input int p);
      for (int i = 0; i < 4; i++)
         if (m[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction
   task automatic grant(input int g);
      owner = g;
      ptr_m = (g + 1) % 4;
      hold_m = 0;
      sel_m = g;
   endtask
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic [3:0] rq, input logic rs);
      int g;
      logic [3:0] oth;
      req = rq;
      reset = rs;
      @(posedge clk);
      if (rs) begin
         owner = -1; ptr_m = 0; hold_m = 0; sel_m = 0;
      end else if (owner < 0) begin
         g = first(rq, ptr_m);
         if (g >= 0) grant(g);
      end else if (rq[owner] && hold_m < MAX_HOLD - 1) begin
         hold_m++;
      end else begin
         oth = rq;
         oth[owner] = 1'b0;
         g = first(oth, ptr_m);
         if (g >= 0) grant(g);
         else if (rq[owner]) hold_m = 0;
         else owner = -1;
      end
      #1;
      vectors++;
      chk("gnt", gnt, owner < 0 ? 4'b0000 : 4'(1 << owner));
      chk("sel", {2'b00, sel}, 4'(sel_m));
      chk("busy", {3'b000, busy}, {3'b000, owner >= 0});
      chk("onehot", {3'b000, $onehot0(gnt)}, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         wait_c[i] = (!rs && rq[i] && !gnt[i]) ? wait_c[i] + 1 : 0;
         chk("starve", {3'b000, wait_c[i] <= 3 * MAX_HOLD}, 4'b0001);
      end
   endtask
   initial begin
      step(4'b0000, 1'b1);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_busy", {3'b000, busy}, 4'b0000);
      step(4'b1111, 1'b0);
      chk("first_gnt", gnt, 4'b0001);
      repeat (7) begin
         step(4'b1111, 1'b0);
         chk("hold_gnt", gnt, 4'b0001);
      end
      step(4'b1111, 1'b0);
      chk("rot_gnt", gnt, 4'b0010);
      chk("rot_sel", {2'b00, sel}, 4'd1);
      step(4'b1111, 1'b1);
      chk("midrst_gnt", gnt, 4'b0000);
      chk("midrst_busy", {3'b000, busy}, 4'b0000);
      step(4'b1111, 1'b0);
      chk("post_rst_gnt", gnt, 4'b0001);
      step(4'b0000, 1'b1);
      repeat (20) begin
         step(4'b0100, 1'b0);
         chk("solo_gnt", gnt, 4'b0100);
         chk("solo_sel", {2'b00, sel}, 4'd2);
      end
      step(4'b0000, 1'b1);
      step(4'b1001, 1'b0);
      chk("own0_gnt", gnt, 4'b0001);
      step(4'b1000, 1'b0);
      chk("handoff_gnt", gnt, 4'b1000);
      chk("handoff_sel", {2'b00, sel}, 4'd3);
      chk("handoff_busy", {3'b000, busy}, 4'b0001);
      step(4'b0000, 1'b0);
      chk("drop_gnt", gnt, 4'b0000);
      chk("drop_busy", {3'b000, busy}, 4'b0000);
      chk("drop_sel", {2'b00, sel}, 4'd3);
      r = 4'b0000;
      repeat (10000) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         step(r, $urandom_range(0, 499) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mux_arbiter4.md
MUX_ARBITER4 -- requirements
Module: mux_arbiter4

Interface
REQ-001 SHALL provide parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before forced rotation when another requester is waiting (legal range 2..15).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: req  input  4  request from requesters 3..0, level-sensitive, held high while access is wanted.
REQ-005 SHALL provide port: gnt  output  4  one-hot grant, all zeros when no owner.
REQ-006 SHALL provide port: sel  output  2  binary index of current owner, drives the 4:1 mux select (en[1:0]).
REQ-007 SHALL provide port: busy  output  1  high when any grant is asserted.
REQ-008 Interface decided: one clock; reset is synchronous and active-high.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and OWNED (exactly one gnt bit high).
REQ-010 All outputs SHALL be registered; gnt, sel and busy SHALL change only on posedge clk.
REQ-011 gnt SHALL always be zero or one-hot; busy SHALL equal |gnt; sel SHALL equal the index of the gnt bit when busy=1.
REQ-012 sel SHALL hold its last value while busy=0.
REQ-013 Internal pointer ptr[1:0] SHALL define rotating priority: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 IDLE: if req!=0 at a clock edge, SHALL enter OWNED with gnt set to the first requester in search order (latency 1 cycle from req to gnt); else remain IDLE.
REQ-015 On every new grant to index k, ptr SHALL update to k+1 (mod 4), and the hold counter SHALL clear to 0.
REQ-016 OWNED, owner's req still high, hold counter < MAX_HOLD-1: SHALL keep grant and increment hold counter.
REQ-017 OWNED, owner's req drops: at that same edge SHALL hand off directly to the next requester in search order (no idle cycle); if no other req high, SHALL go to IDLE with gnt=0.
REQ-018 OWNED, owner's req high and hold counter = MAX_HOLD-1: if any other req high, SHALL rotate to the first other requester in search order; if none, SHALL keep the owner and clear the hold counter.
REQ-019 Simultaneous requests SHALL be resolved solely by ptr order; no requester SHALL wait more than 3*MAX_HOLD cycles while continuously requesting.
REQ-020 Hold counter SHALL be 4 bits and SHALL never wrap beyond MAX_HOLD-1.
REQ-021 A req pulse shorter than one cycle between edges SHALL be ignored; a requester granted whose req is low at the next edge loses the grant per REQ-017.

Reset
REQ-022 When reset=1 at a clock edge: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, ptr=0, hold counter=0, regardless of current state or req.
REQ-023 Reset SHALL take priority over all grant logic, including mid-grant; first grant after reset deassertion follows REQ-014 with ptr=0.

Verification
REQ-024 Reset then req=4'b1111 -> next edge gnt=4'b0001, sel=0, busy=1; hold 8 cycles then gnt=4'b0010, sel=1.
REQ-025 req=4'b0100 alone held 20 cycles -> gnt=4'b0100 continuously, no rotation, sel=2.
REQ-026 Owner 0 granted, req=4'b1001 then req[0] drops -> next edge gnt=4'b1000, sel=3, busy stays 1 (no idle gap).
REQ-027 Single owner drops req with no others -> next edge gnt=0, busy=0, sel holds last value.
REQ-028 reset=1 asserted mid-grant with req=4'b1111 -> next edge gnt=0, busy=0; after release first grant is gnt=4'b0001.
REQ-029 Random req for 10000 cycles -> gnt always zero/one-hot, sel matches gnt, no requester starved beyond 24 cycles (MAX_HOLD=8).
